// File: rtl/ysyx_24120013_pkg.sv
// Shared decode constants for the NPC front end: command encodings,
// opcode/funct values and immediate formats.
package ysyx_24120013_pkg;

  localparam int CMD_WIDTH = 4;

  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_NOP     = 4'd0,
    CMD_ADDI    = 4'd1,
    CMD_LUI     = 4'd2,
    CMD_AUIPC   = 4'd3,
    CMD_ADD     = 4'd4,
    CMD_JAL     = 4'd5,
    CMD_JALR    = 4'd6,
    CMD_EBREAK  = 4'd7,
    CMD_ILLEGAL = 4'd15
  } cmd_e;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_U,
    IMM_J
  } imm_type_e;

  localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI     = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0]  OPC_OP      = 7'b0110011;
  localparam logic [6:0]  OPC_JAL     = 7'b1101111;
  localparam logic [6:0]  OPC_JALR    = 7'b1100111;
  localparam logic [2:0]  F3_ADD      = 3'b000;
  localparam logic [6:0]  F7_ADD      = 7'b0000000;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/ysyx_24120013_imm_gen.sv
// Combinational immediate extraction: classifies the format from the opcode
// and produces the sign-extended immediate (zero for formats without one).
module ysyx_24120013_imm_gen
  import ysyx_24120013_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [6:0]            opcode,
  input  logic [31:12]          inst_hi,
  output imm_type_e             imm_type,
  output logic [DATA_WIDTH-1:0] imm
);

  always_comb begin
    imm_type = IMM_NONE;
    unique case (opcode)
      OPC_OP_IMM, OPC_JALR: imm_type = IMM_I;
      OPC_LUI, OPC_AUIPC:   imm_type = IMM_U;
      OPC_JAL:              imm_type = IMM_J;
      default:              imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (imm_type)
      IMM_I:   imm = DATA_WIDTH'($signed(inst_hi[31:20]));
      IMM_U:   imm = DATA_WIDTH'($signed({inst_hi[31:12], 12'b0}));
      IMM_J:   imm = DATA_WIDTH'($signed({inst_hi[31], inst_hi[19:12], inst_hi[20],
                                          inst_hi[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24120013_idu.sv
// NPC decode stage: decodes the RV32 subset, reads operands, tracks in-flight
// destinations in a busy scoreboard and holds the issued bundle for the EXU.
module ysyx_24120013_idu
  import ysyx_24120013_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CMD_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_inst,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr1,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0]     rf_rdata1,
  input  logic [DATA_WIDTH-1:0]     rf_rdata2,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_imm,
  output logic [DATA_WIDTH-1:0]     out_src1,
  output logic [DATA_WIDTH-1:0]     out_src2,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [REG_ADDR_WIDTH-1:0] out_des,
  output logic [CMD_WIDTH-1:0]      out_command,
  output logic                      halted
);

  localparam int NREG = 1 << REG_ADDR_WIDTH;

  logic [6:0]                opcode, funct7;
  logic [2:0]                funct3;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  imm_type_e                 imm_type;
  logic [DATA_WIDTH-1:0]     imm_raw, imm_dec, src1_dec, src2_dec;
  cmd_e                      cmd;
  logic                      uses_rs1, uses_rs2, writes_rd;
  logic [REG_ADDR_WIDTH-1:0] des_dec;
  logic                      hazard, issue;
  logic [NREG-1:0]           busy, busy_d;

  logic                      vld_p1, halted_q;
  logic [DATA_WIDTH-1:0]     imm_p1, src1_p1, src2_p1, pc_p1;
  logic [REG_ADDR_WIDTH-1:0] des_p1;
  cmd_e                      cmd_p1;

  assign opcode = in_inst[6:0];
  assign rd     = in_inst[7 +: REG_ADDR_WIDTH];
  assign funct3 = in_inst[14:12];
  assign rs1    = in_inst[15 +: REG_ADDR_WIDTH];
  assign rs2    = in_inst[20 +: REG_ADDR_WIDTH];
  assign funct7 = in_inst[31:25];

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  ysyx_24120013_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .opcode   (opcode),
    .inst_hi  (in_inst[31:12]),
    .imm_type (imm_type),
    .imm      (imm_raw)
  );

  always_comb begin
    cmd       = CMD_ILLEGAL;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    if (in_inst[31:0] == INST_EBREAK) begin
      cmd = CMD_EBREAK;
    end else begin
      unique case (opcode)
        OPC_OP_IMM: if (funct3 == F3_ADD) begin
          cmd = CMD_ADDI; uses_rs1 = 1'b1; writes_rd = 1'b1;
        end
        OPC_LUI:   begin cmd = CMD_LUI;   writes_rd = 1'b1; end
        OPC_AUIPC: begin cmd = CMD_AUIPC; writes_rd = 1'b1; end
        OPC_OP: if (funct3 == F3_ADD && funct7 == F7_ADD) begin
          cmd = CMD_ADD; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
        end
        OPC_JAL:   begin cmd = CMD_JAL;   writes_rd = 1'b1; end
        OPC_JALR: if (funct3 == F3_ADD) begin
          cmd = CMD_JALR; uses_rs1 = 1'b1; writes_rd = 1'b1;
        end
        default: cmd = CMD_ILLEGAL;
      endcase
    end
  end

  // Operands the instruction does not use, and x0 reads, are forced to zero.
  assign imm_dec  = (imm_type == IMM_NONE || cmd == CMD_ILLEGAL) ? '0 : imm_raw;
  assign src1_dec = (uses_rs1 && rs1 != '0) ? rf_rdata1 : '0;
  assign src2_dec = (uses_rs2 && rs2 != '0) ? rf_rdata2 : '0;
  assign des_dec  = writes_rd ? rd : '0;

  assign hazard   = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & busy[rd]);
  assign in_ready = ~rst & ~halted_q & ~hazard & (~vld_p1 | out_ready);
  assign issue    = in_valid & in_ready;

  always_comb begin
    busy_d = busy;
    if (wb_en && wb_addr != '0) busy_d[wb_addr] = 1'b0;
    if (issue && writes_rd && rd != '0) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Stage p1: issued bundle register feeding the EXU
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      imm_p1   <= '0;
      src1_p1  <= '0;
      src2_p1  <= '0;
      pc_p1    <= '0;
      des_p1   <= '0;
      cmd_p1   <= CMD_NOP;
      halted_q <= 1'b0;
      busy     <= '0;
    end else begin
      busy <= busy_d;
      if (issue) begin
        vld_p1  <= 1'b1;
        imm_p1  <= imm_dec;
        src1_p1 <= src1_dec;
        src2_p1 <= src2_dec;
        pc_p1   <= in_pc;
        des_p1  <= des_dec;
        cmd_p1  <= cmd;
        if (cmd == CMD_EBREAK) halted_q <= 1'b1;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign out_imm     = imm_p1;
  assign out_src1    = src1_p1;
  assign out_src2    = src2_p1;
  assign out_pc      = pc_p1;
  assign out_des     = des_p1;
  assign out_command = CMD_WIDTH'(cmd_p1);
  assign halted      = halted_q;

endmodule

// File: tb/tb_ysyx_24120013_idu.sv
// Directed bench for the decode stage: a reference decoder predicts each
// issued bundle and a queue matches predictions against consumed bundles.
module tb_ysyx_24120013_idu;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_en, out_valid, out_ready, halted;
  logic [31:0] in_inst, in_pc, rf_rdata1, rf_rdata2;
  logic [31:0] out_imm, out_src1, out_src2, out_pc;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_addr, out_des;
  logic [3:0]  out_command;
  logic [31:0] regs [32];

  typedef struct packed {
    logic [31:0] imm, src1, src2, pc;
    logic [4:0]  des;
    logic [3:0]  cmd;
  } bundle_t;

  bundle_t q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  ysyx_24120013_idu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_en(wb_en), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_src1(out_src1), .out_src2(out_src2), .out_pc(out_pc), .out_des(out_des),
    .out_command(out_command), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t model(input logic [31:0] inst, input logic [31:0] pc);
    bundle_t b;
    logic u1, u2, w;
    b = '0; b.pc = pc; u1 = 1'b0; u2 = 1'b0; w = 1'b0;
    b.cmd = 4'd15;
    if (inst == 32'h0010_0073) b.cmd = 4'd7;
    else case (inst[6:0])
      7'h13: if (inst[14:12] == 3'd0) begin
        b.cmd = 4'd1; u1 = 1'b1; w = 1'b1; b.imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'h37: begin b.cmd = 4'd2; w = 1'b1; b.imm = {inst[31:12], 12'h000}; end
      7'h17: begin b.cmd = 4'd3; w = 1'b1; b.imm = {inst[31:12], 12'h000}; end
      7'h33: if (inst[14:12] == 3'd0 && inst[31:25] == 7'd0) begin
        b.cmd = 4'd4; u1 = 1'b1; u2 = 1'b1; w = 1'b1;
      end
      7'h6f: begin
        b.cmd = 4'd5; w = 1'b1;
        b.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'h67: if (inst[14:12] == 3'd0) begin
        b.cmd = 4'd6; u1 = 1'b1; w = 1'b1; b.imm = {{20{inst[31]}}, inst[31:20]};
      end
      default: b.cmd = 4'd15;
    endcase
    if (w) b.des = inst[11:7];
    if (u1 && inst[19:15] != 5'd0) b.src1 = regs[inst[19:15]];
    if (u2 && inst[24:20] != 5'd0) b.src2 = regs[inst[24:20]];
    return b;
  endfunction

  // Consumption is compared before the same cycle's issue is recorded.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        tests++;
        assert (q.size() != 0) else begin
          fails++;
          $error("FAIL sb_unexpected observed pc=%h expected no bundle", out_pc);
        end
        if (q.size() != 0) begin
          bundle_t e;
          e = q.pop_front();
          chk("sb_imm", out_imm, e.imm);
          chk("sb_src1", out_src1, e.src1);
          chk("sb_src2", out_src2, e.src2);
          chk("sb_pc", out_pc, e.pc);
          chk("sb_des", {27'd0, out_des}, {27'd0, e.des});
          chk("sb_cmd", {28'd0, out_command}, {28'd0, e.cmd});
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_inst, in_pc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i * 32'h0101;
    regs[0]   = 32'hDEAD_BEEF;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inst   = 32'h0;
    in_pc     = 32'h0;
    wb_en     = 1'b0;
    wb_addr   = 5'd0;
    out_ready = 1'b1;

    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_cmd", {28'd0, out_command}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDI x1,x0,5 then dependent ADD x2,x1,x1
    present(32'h0050_0093, 32'h8000_0000);
    chk("addi_ready", {31'd0, in_ready}, 32'd1);
    tick();
    present(32'h0010_8133, 32'h8000_0004);
    chk("raw_stall", {31'd0, in_ready}, 32'd0);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_cmd", {28'd0, out_command}, 32'd1);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_src1_x0", out_src1, 32'd0);
    chk("addi_des", {27'd0, out_des}, 32'd1);
    tick();
    chk("raw_stall_hold", {31'd0, in_ready}, 32'd0);
    chk("valid_clear", {31'd0, out_valid}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd1;
    #1;
    chk("no_wb_bypass", {31'd0, in_ready}, 32'd0);
    tick();
    wb_en = 1'b0;
    #1;
    chk("raw_release", {31'd0, in_ready}, 32'd1);
    tick();

    // LUI x3,0xFFFFF held under backpressure
    present(32'hFFFF_F1B7, 32'h8000_0008);
    chk("lui_ready", {31'd0, in_ready}, 32'd1);
    tick();
    out_ready = 1'b0;
    present(32'h0070_0213, 32'h8000_000C);
    chk("backpressure", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_imm", out_imm, 32'hFFFF_F000);
      chk("hold_pc", out_pc, 32'h8000_0008);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Illegal word sets no busy bit (rd field = 31)
    present(32'hFFFF_FFFF, 32'h8000_0100);
    tick();
    present(32'h001F_8F93, 32'h8000_0104);
    chk("illegal_cmd", {28'd0, out_command}, 32'd15);
    chk("illegal_des", {27'd0, out_des}, 32'd0);
    chk("illegal_no_busy", {31'd0, in_ready}, 32'd1);
    tick();

    // JAL x1,-4 then JALR x5,8(x2) waiting on x2
    present(32'hFFDF_F0EF, 32'h8000_0010);
    chk("jal_ready", {31'd0, in_ready}, 32'd1);
    tick();
    present(32'h0081_02E7, 32'h8000_0014);
    chk("jal_imm", out_imm, 32'hFFFF_FFFC);
    chk("jal_pc", out_pc, 32'h8000_0010);
    chk("jalr_raw_x2", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd2;
    tick();
    wb_en = 1'b0;
    #1;
    chk("jalr_release", {31'd0, in_ready}, 32'd1);
    tick();

    // AUIPC x6 then WAW on x6
    present(32'h1234_5317, 32'h8000_0018);
    tick();
    present(32'h0010_0313, 32'h8000_001C);
    chk("waw_stall", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd6;
    tick();
    wb_en = 1'b0;
    #1;
    chk("waw_release", {31'd0, in_ready}, 32'd1);
    tick();

    // Same-cycle set of x7 and clear of x5
    present(32'h0020_0393, 32'h8000_0020);
    wb_en = 1'b1; wb_addr = 5'd5;
    #1;
    chk("setclr_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_en = 1'b0;
    present(32'h0002_8413, 32'h8000_0024);
    chk("clear_applied", {31'd0, in_ready}, 32'd1);
    tick();
    present(32'h0003_8493, 32'h8000_0028);
    chk("set_applied", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd7;
    tick();
    wb_en = 1'b0;
    #1;
    chk("x7_release", {31'd0, in_ready}, 32'd1);
    tick();

    // EBREAK halts; bundle held across reset and discarded
    present(32'h0010_0073, 32'h8000_0030);
    chk("ebreak_ready", {31'd0, in_ready}, 32'd1);
    tick();
    out_ready = 1'b0;
    present(32'h0000_0013, 32'h8000_0034);
    chk("halted_set", {31'd0, halted}, 32'd1);
    chk("ebreak_cmd", {28'd0, out_command}, 32'd7);
    chk("halted_ready", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b1;
    #1;
    chk("halted_ready_hold", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_cycle_ready", {31'd0, in_ready}, 32'd0);
    tick();
    q.delete();
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_pc", out_pc, 32'd0);
    chk("rst2_cmd", {28'd0, out_command}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    present(32'h0010_8133, 32'h8000_0040);
    chk("busy_reset", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained", q.size(), 32'd0);
    chk("final_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_24120013_idu.md
# ysyx_24120013_idu

Decode stage of the NPC core, directly upstream of the EXU. Accepts 32-bit instructions from the IFU over a valid/ready handshake, decodes the RV32 subset the core implements, reads source operands from the register file, and holds the decoded bundle (`imm`, `src1`, `src2`, `des`, `command`) in an output pipeline register that feeds the EXU. A per-register busy scoreboard stalls issue on RAW/WAW hazards until the EXU result is written back.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/immediate/instruction width
- `REG_ADDR_WIDTH`, 5, register index width (32 GPRs, x0 hard zero)
- `CMD_WIDTH`, 4, width of `command` to EXU

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1, sole clock
- `rst` in 1, synchronous active-high reset
- `in_valid` in 1, IFU has an instruction
- `in_ready` out 1, IDU accepts this cycle
- `in_inst` in DATA_WIDTH, instruction word
- `in_pc` in DATA_WIDTH, its PC
- `rf_raddr1`, `rf_raddr2` out REG_ADDR_WIDTH, combinational register-file read indices (= inst[19:15], inst[24:20])
- `rf_rdata1`, `rf_rdata2` in DATA_WIDTH, combinational read data
- `wb_en` in 1, writeback strobe from EXU/WB
- `wb_addr` in REG_ADDR_WIDTH, writeback index
- `out_valid` out 1, decoded bundle valid
- `out_ready` in 1, EXU consumes this cycle
- `out_imm`, `out_src1`, `out_src2`, `out_pc` out DATA_WIDTH
- `out_des` out REG_ADDR_WIDTH, destination (0 = no write)
- `out_command` out CMD_WIDTH
- `halted` out 1, EBREAK issued

## Operation
- Commands: NOP=0, ADDI=1 (src1+imm), LUI=2, AUIPC=3, ADD=4, JAL=5, JALR=6, EBREAK=7, ILLEGAL=15.
- Immediates sign-extended to DATA_WIDTH: I (ADDI, JALR), U (`inst[31:12]<<12`), J (JAL, bit0=0). Unused fields drive 0.
- `uses_rs1`: ADDI, ADD, JALR. `uses_rs2`: ADD. `writes_rd`: ADDI, LUI, AUIPC, ADD, JAL, JALR.
- Unrecognised opcode/funct3/funct7 → ILLEGAL, `des`=0, `imm`=0; still issued (EXU treats as fault).
- EBREAK (`0x00100073`) → command EBREAK, `des`=0; on issue `halted` sets and stays 1 until reset; `in_ready`=0 while halted.
- Scoreboard `busy[31:0]`, `busy[0]` constant 0.
  - hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & busy[rd]).
  - Issue (`in_valid & in_ready`) with writes_rd and rd≠0 sets `busy[rd]` next edge.
  - `wb_en & wb_addr≠0` clears `busy[wb_addr]` next edge.
  - Hazard check uses registered `busy` only; no same-cycle bypass of `wb_en`.
- Register file reads are sampled into `out_src1/2` at issue; x0 reads force 0 regardless of `rf_rdata`.

## Timing
- `in_ready = ~rst & ~halted & ~hazard & (~out_valid | out_ready)`; combinational, depends on `in_inst` only through hazard.
- Latency: instruction accepted at edge N appears on `out_*` with `out_valid`=1 after edge N; one cycle.
- Back-to-back: full throughput when `out_ready`=1 and no hazard.
- `out_valid` & `out_*` held stable while `out_valid & ~out_ready`.
- `out_valid` clears on `out_ready` without new issue.
- Set and clear of the same `busy` bit in one cycle cannot occur (WAW stall); set/clear of different bits both apply.
- Writeback to reg r at edge N: dependent instruction can issue no earlier than the cycle after edge N.
- Reset (any cycle, including mid-stall): `out_valid`=0, all `out_*`=0, `busy`=0, `halted`=0; in-flight bundle discarded; `in_ready`=0 during the reset cycle.

## Structure
- Shared package `ysyx_24120013_pkg`: command encodings, opcode/funct constants, CMD_WIDTH.
- One natural sub-module: `ysyx_24120013_imm_gen` (combinational instruction → imm + type). Scoreboard and pipe register stay inline.

## Test plan
- ADDI x1,x0,5 (`0x00500093`), `out_ready`=1 → next cycle `out_valid`=1, command=1, imm=5, src1=0, des=1, `busy[1]`=1.
- Then ADD x2,x1,x1 presented → `in_ready`=0 until `wb_en`/`wb_addr`=1 pulse; issues cycle after, src1=src2=`rf_rdata1`.
- LUI x3,0xFFFFF with `out_ready`=0 for 3 cycles → bundle imm=0xFFFFF000 held stable, `in_ready`=0; accepts next on release.
- Word `0xFFFFFFFF` → command=15, des=0, imm=0, no busy bit set.
- EBREAK issued → `halted`=1, `in_ready`=0 permanently; `rst` pulse → `halted`=0, `out_valid`=0, `busy`=0.
- JAL x1,-4 at pc 0x80000010 → imm=0xFFFFFFFC, out_pc=0x80000010, command=5.
